minmax_frame_acc: RTL
=====================

// Module: minmax_frame_acc
// PURPOSE
//  Downstream consumer of the per-cycle Min/Max comparator stage. Accepts one (min,max) pair per
//  valid/ready handshake and folds FRAME_LEN pairs into a frame-wide minimum and maximum.
//  Reports the frame minimum, maximum and range (max-min) through a valid/ready output port.
//  Sits between the comparator and the statistics/reporting logic.
// PARAMETERS
//  WIDTH      8   data width of in_min/in_max and all data outputs
//  FRAME_LEN  16  pairs per frame; legal range 1..2**16-1; internal counter is $clog2(FRAME_LEN+1) bits
// PORTS
//  clk        in   1      single clock; all logic on posedge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      upstream pair valid
//  in_ready   out  1      block can accept a pair this cycle
//  in_min     in   WIDTH  upstream Min
//  in_max     in   WIDTH  upstream Max
//  out_valid  out  1      frame result valid
//  out_ready  in   1      downstream accepts the result
//  out_min    out  WIDTH  frame minimum (unsigned)
//  out_max    out  WIDTH  frame maximum (unsigned)
//  out_range  out  WIDTH  out_max - out_min; never negative
//  err_count  out  8      present only with MINMAX_ACC_ERR_CNT_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, count=0, accumulators=0, out_valid=0,
//    out_min/out_max/out_range=0, in_ready=0 while rst is high.
//  - Accept = in_valid && in_ready, sampled on posedge. Compare all data as unsigned.
//  - Pair sanitising: if in_min > in_max, swap the two values before use. Comparator output is
//    invalid around reset, so this swap is mandatory.
//  - States:
//      IDLE:  in_ready=1. On accept, load acc_min/acc_max from the pair, set count=1.
//             Go to HOLD if FRAME_LEN==1, else go to ACCUM.
//      ACCUM: in_ready=1. On accept, update acc_min=min(acc_min,pair.min) and
//             acc_max=max(acc_max,pair.max), and increment count.
//             When count reaches FRAME_LEN, go to HOLD.
//      HOLD:  in_ready=0, out_valid=1. out_min, out_max and out_range are registered and stay
//             stable until the handshake. On out_valid && out_ready, go to IDLE and set count=0.
//  - Latency: out_valid rises on the edge that follows the accept of the FRAME_LEN-th pair.
//    Registered outputs update on that same edge.
//  - After the output handshake there is exactly one IDLE cycle with in_ready=1 before
//    accumulation resumes; no pair is lost or reordered. If out_ready is high when out_valid
//    rises, the handshake completes on the next edge.
//  - No accept occurs when in_valid is low. Gaps of any length inside a frame are legal and do
//    not change the result.
//  - Equal values (in_min==in_max, or a frame of all-equal pairs) give out_range=0.
//  - Extremes 0 and 2**WIDTH-1 are legal. out_range can be 2**WIDTH-1 and needs no extra bit.
//  - Reset mid-frame discards the partial frame. The first accept after reset starts a new frame.
//  - out_* hold their last value after the handshake until the next frame completes.
//    out_valid is the only qualifier.
// CONFIGURATION
//  MINMAX_ACC_ERR_CNT_EN defined:
//    - Adds output port err_count[7:0], reset to 0.
//    - err_count increments on every accepted pair that needed a swap and saturates at 255.
//    - err_count is never cleared by frames; only rst clears it.
//  MINMAX_ACC_ERR_CNT_EN undefined:
//    - err_count port and its logic are absent.
//    - The swap is still performed, so data behaviour is identical.
// TESTING (WIDTH=8, FRAME_LEN=4 unless stated)
//  1. Pairs (10,20),(5,30),(7,8),(12,25) back-to-back with out_ready=1
//     -> one cycle later out_valid=1, min=5, max=30, range=25.
//  2. Swapped pair (40,3) plus (10,10),(10,10),(10,10)
//     -> min=3, max=40, range=37; with macro, err_count=1.
//  3. out_ready=0 for 5 cycles after out_valid
//     -> outputs stable, in_ready=0, in_valid pulses ignored.
//     Raise out_ready -> IDLE, next frame correct.
//  4. rst pulse after 2 accepted pairs (1,2),(3,4); then (50,60)x4
//     -> outputs 0 during reset, result min=50, max=60, range=10.
//  5. FRAME_LEN=1: (0,255) -> out_valid next cycle, range=255; (9,9) -> range=0.
//  6. Random in_valid gaps over 1000 frames -> scoreboard min/max/range exact;
//     no accept while in HOLD.

Source files
------------

// File: rtl/minmax_frame_acc_if.sv
// minmax_frame_acc_if
//   Handshake bundle between the min/max comparator, the frame accumulator
//   and the downstream statistics logic.
//   Input side  : in_valid, in_ready, in_min, in_max
//   Output side : out_valid, out_ready, out_min, out_max, out_range
//   Modports    : master = producer of pairs / consumer of results (upstream/downstream)
//                 slave  = the accumulator itself
interface minmax_frame_acc_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_min;
  logic [WIDTH-1:0] in_max;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_min;
  logic [WIDTH-1:0] out_max;
  logic [WIDTH-1:0] out_range;

  modport master (
    output in_valid, in_min, in_max, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_range
  );

  modport slave (
    input  in_valid, in_min, in_max, out_ready,
    output in_ready, out_valid, out_min, out_max, out_range
  );
endinterface

// File: rtl/minmax_frame_acc.sv
// minmax_frame_acc
//   Folds FRAME_LEN (min,max) pairs into a frame-wide unsigned minimum and
//   maximum and reports min, max and range (max-min) over a valid/ready port.
//   Ports:
//     clk        clock, all logic on posedge
//     rst        asynchronous active-high reset
//     bus        minmax_frame_acc_if.slave (pair input and frame result output)
//     err_count  8-bit saturating count of accepted pairs that arrived with
//                min > max; only present when MINMAX_ACC_ERR_CNT_EN is defined
//   Optional feature macro: MINMAX_ACC_ERR_CNT_EN
//
//   state | meaning
//   IDLE  | waiting for the first pair of a frame, in_ready=1
//   ACCUM | folding pairs 2..FRAME_LEN, in_ready=1
//   HOLD  | result presented, out_valid=1, in_ready=0 until out_ready
module minmax_frame_acc #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 16
) (
  input  logic clk,
  input  logic rst,
`ifdef MINMAX_ACC_ERR_CNT_EN
  output logic [7:0] err_count,
`endif
  minmax_frame_acc_if.slave bus
);

  localparam int CW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_min;
  logic [WIDTH-1:0] acc_max;

  logic             accept;
  logic             swap;
  logic             last;
  logic [WIDTH-1:0] p_min;
  logic [WIDTH-1:0] p_max;
  logic [WIDTH-1:0] n_min;
  logic [WIDTH-1:0] n_max;

  // Comparator output is untrustworthy around its own reset, so every pair
  // is ordered before it is folded in.
  always_comb begin
    accept = bus.in_valid && bus.in_ready;
    swap   = bus.in_min > bus.in_max;
    p_min  = swap ? bus.in_max : bus.in_min;
    p_max  = swap ? bus.in_min : bus.in_max;
    if (state == IDLE) begin
      n_min = p_min;
      n_max = p_max;
      last  = (FRAME_LEN == 1);
    end else begin
      n_min = (p_min < acc_min) ? p_min : acc_min;
      n_max = (p_max > acc_max) ? p_max : acc_max;
      last  = (count == CW'(FRAME_LEN - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      acc_min       <= '0;
      acc_max       <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_min   <= '0;
      bus.out_max   <= '0;
      bus.out_range <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          bus.in_ready <= 1'b1;
          if (accept) begin
            acc_min <= n_min;
            acc_max <= n_max;
            count   <= (state == IDLE) ? CW'(1) : count + 1'b1;
            if (last) begin
              // Result registers load on the same edge that out_valid rises.
              state         <= HOLD;
              bus.in_ready  <= 1'b0;
              bus.out_valid <= 1'b1;
              bus.out_min   <= n_min;
              bus.out_max   <= n_max;
              bus.out_range <= n_max - n_min;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            count         <= '0;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b0;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MINMAX_ACC_ERR_CNT_EN
  // Survives frame boundaries; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (accept && swap && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
